// File: rtl/pi_loop_sequencer.sv
// Control-loop sequencer: arms the ADC, shadows the pipeline operands, waits out the PI
// pipeline latency, stores the integral and writes the saturated word to the DAC.
// Optional macro INTEGRAL_CLAMP_EN clamps the stored integral to +/-INTEGRAL_MAX.
module pi_loop_sequencer #(
  parameter int INPUT_WIDTH  = 18,
  parameter int OUTPUT_WIDTH = 32,
  parameter int DAC_WIDTH    = 20,
  parameter int PIPE_LATENCY = 4,
  parameter int INTEGRAL_MAX = 1 << 30
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_enable,
  input  logic [INPUT_WIDTH-1:0]  i_setpoint,
  input  logic [INPUT_WIDTH-1:0]  i_kp,
  input  logic [INPUT_WIDTH-1:0]  i_ki,
  output logic                    o_adc_arm,
  input  logic                    i_adc_finished,
  input  logic [INPUT_WIDTH-1:0]  i_adc_data,
  output logic [INPUT_WIDTH-1:0]  o_actual,
  output logic [INPUT_WIDTH-1:0]  o_setpoint,
  output logic [INPUT_WIDTH-1:0]  o_kp,
  output logic [INPUT_WIDTH-1:0]  o_ki,
  output logic [OUTPUT_WIDTH-1:0] o_integral,
  input  logic [OUTPUT_WIDTH-1:0] i_integral,
  input  logic [OUTPUT_WIDTH-1:0] i_pd_out,
  output logic                    o_dac_arm,
  input  logic                    i_dac_finished,
  output logic [DAC_WIDTH-1:0]    o_dac_data,
  output logic                    o_loop_done
);

  typedef enum logic [2:0] {IDLE, ADC_WAIT, PIPE_WAIT, DAC_WAIT, REARM} state_e;

  localparam int CNT_W = $clog2(PIPE_LATENCY + 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PIPE_LATENCY);
  localparam logic signed [OUTPUT_WIDTH-1:0] DAC_MAX =
    OUTPUT_WIDTH'((64'sd1 <<< (DAC_WIDTH - 1)) - 64'sd1);
  localparam logic signed [OUTPUT_WIDTH-1:0] DAC_MIN = ~DAC_MAX;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    adc_arm_q, adc_arm_d;
  logic                    dac_arm_q, dac_arm_d;
  logic                    loop_done_q, loop_done_d;
  logic [INPUT_WIDTH-1:0]  actual_q, actual_d;
  logic [INPUT_WIDTH-1:0]  setpoint_q, setpoint_d;
  logic [INPUT_WIDTH-1:0]  kp_q, kp_d;
  logic [INPUT_WIDTH-1:0]  ki_q, ki_d;
  logic [OUTPUT_WIDTH-1:0] integral_q, integral_d;
  logic [DAC_WIDTH-1:0]    dac_data_q, dac_data_d;

  function automatic logic [DAC_WIDTH-1:0] sat_dac(input logic signed [OUTPUT_WIDTH-1:0] x);
    if (x > DAC_MAX)      return DAC_MAX[DAC_WIDTH-1:0];
    else if (x < DAC_MIN) return DAC_MIN[DAC_WIDTH-1:0];
    else                  return x[DAC_WIDTH-1:0];
  endfunction

`ifdef INTEGRAL_CLAMP_EN
  localparam logic signed [OUTPUT_WIDTH-1:0] INT_MAX_S = OUTPUT_WIDTH'(INTEGRAL_MAX);
  localparam logic signed [OUTPUT_WIDTH-1:0] INT_MIN_S = -INT_MAX_S;

  function automatic logic [OUTPUT_WIDTH-1:0] clamp_int(input logic signed [OUTPUT_WIDTH-1:0] x);
    if (x > INT_MAX_S)      return INT_MAX_S;
    else if (x < INT_MIN_S) return INT_MIN_S;
    else                    return x;
  endfunction
`else
  function automatic logic [OUTPUT_WIDTH-1:0] clamp_int(input logic signed [OUTPUT_WIDTH-1:0] x);
    return x;
  endfunction
`endif

  // NOTE: every next-state value gets its default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    adc_arm_d   = adc_arm_q;
    dac_arm_d   = dac_arm_q;
    loop_done_d = 1'b0;
    actual_d    = actual_q;
    setpoint_d  = setpoint_q;
    kp_d        = kp_q;
    ki_d        = ki_q;
    integral_d  = integral_q;
    dac_data_d  = dac_data_q;

    unique case (state_q)
      IDLE: begin
        if (i_enable && !i_adc_finished) begin
          adc_arm_d = 1'b1;
          state_d   = ADC_WAIT;
        end
      end
      ADC_WAIT: begin
        // The operand shadows move only here, so the pipeline sees a stable iteration.
        if (i_adc_finished) begin
          actual_d   = i_adc_data;
          setpoint_d = i_setpoint;
          kp_d       = i_kp;
          ki_d       = i_ki;
          adc_arm_d  = 1'b0;
          cnt_d      = '0;
          state_d    = PIPE_WAIT;
        end
      end
      PIPE_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          integral_d = clamp_int($signed(i_integral));
          dac_data_d = sat_dac($signed(i_pd_out));
          dac_arm_d  = 1'b1;
          state_d    = DAC_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DAC_WAIT: begin
        if (i_dac_finished) begin
          dac_arm_d   = 1'b0;
          loop_done_d = 1'b1;
          state_d     = REARM;
        end
      end
      REARM: begin
        // Stale finished levels from the last handshake must clear before re-arming.
        if (!i_adc_finished && !i_dac_finished) begin
          if (i_enable) begin
            adc_arm_d = 1'b1;
            state_d   = ADC_WAIT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      adc_arm_q   <= 1'b0;
      dac_arm_q   <= 1'b0;
      loop_done_q <= 1'b0;
      actual_q    <= '0;
      setpoint_q  <= '0;
      kp_q        <= '0;
      ki_q        <= '0;
      integral_q  <= '0;
      dac_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      adc_arm_q   <= adc_arm_d;
      dac_arm_q   <= dac_arm_d;
      loop_done_q <= loop_done_d;
      actual_q    <= actual_d;
      setpoint_q  <= setpoint_d;
      kp_q        <= kp_d;
      ki_q        <= ki_d;
      integral_q  <= integral_d;
      dac_data_q  <= dac_data_d;
    end
  end

  assign o_adc_arm   = adc_arm_q;
  assign o_dac_arm   = dac_arm_q;
  assign o_loop_done = loop_done_q;
  assign o_actual    = actual_q;
  assign o_setpoint  = setpoint_q;
  assign o_kp        = kp_q;
  assign o_ki        = ki_q;
  assign o_integral  = integral_q;
  assign o_dac_data  = dac_data_q;

endmodule

// File: tb/tb_pi_loop_sequencer.sv
// Self-checking bench for pi_loop_sequencer: a behavioural PI pipeline and scripted
// ADC/DAC handshakes, with expectations from a loop-level reference model.
module tb_pi_loop_sequencer;

  localparam int IW      = 18;
  localparam int OW      = 32;
  localparam int DW      = 20;
  localparam int PL      = 4;
  localparam int INT_MAX = 150;
  localparam longint DAC_HI = (64'sd1 <<< (DW - 1)) - 1;
  localparam longint DAC_LO = -(64'sd1 <<< (DW - 1));

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 i_enable;
  logic signed [IW-1:0] i_setpoint, i_kp, i_ki, i_adc_data;
  logic                 i_adc_finished, i_dac_finished;
  logic [OW-1:0]        i_integral, i_pd_out;
  logic                 o_adc_arm, o_dac_arm, o_loop_done;
  logic [IW-1:0]        o_actual, o_setpoint, o_kp, o_ki;
  logic [OW-1:0]        o_integral;
  logic [DW-1:0]        o_dac_data;

  int total = 0;
  int bad   = 0;
  longint model_int = 0;

  always #5 clk = ~clk;

  pi_loop_sequencer #(
    .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .DAC_WIDTH(DW),
    .PIPE_LATENCY(PL), .INTEGRAL_MAX(INT_MAX)
  ) dut (
    .clk(clk), .rst(rst), .i_enable(i_enable),
    .i_setpoint(i_setpoint), .i_kp(i_kp), .i_ki(i_ki),
    .o_adc_arm(o_adc_arm), .i_adc_finished(i_adc_finished), .i_adc_data(i_adc_data),
    .o_actual(o_actual), .o_setpoint(o_setpoint), .o_kp(o_kp), .o_ki(o_ki),
    .o_integral(o_integral), .i_integral(i_integral), .i_pd_out(i_pd_out),
    .o_dac_arm(o_dac_arm), .i_dac_finished(i_dac_finished), .o_dac_data(o_dac_data),
    .o_loop_done(o_loop_done)
  );

  // Behavioural PI pipeline: error = actual - setpoint, PL register stages deep.
  logic signed [63:0] p_err, p_int_now, p_pd_now;
  logic [OW-1:0]      p_int [PL];
  logic [OW-1:0]      p_pd  [PL];
  assign p_err     = 64'($signed(o_actual)) - 64'($signed(o_setpoint));
  assign p_int_now = 64'($signed(o_integral)) + 64'($signed(o_ki)) * p_err;
  assign p_pd_now  = 64'($signed(o_kp)) * p_err + p_int_now;

  always @(posedge clk) begin
    p_int[0] <= p_int_now[OW-1:0];
    p_pd[0]  <= p_pd_now[OW-1:0];
    for (int s = 1; s < PL; s++) begin
      p_int[s] <= p_int[s-1];
      p_pd[s]  <= p_pd[s-1];
    end
  end
  assign i_integral = p_int[PL-1];
  assign i_pd_out   = p_pd[PL-1];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint sat_ref(input longint x);
    if (x > DAC_HI) return DAC_HI;
    if (x < DAC_LO) return DAC_LO;
    return x;
  endfunction

  function automatic longint clamp_ref(input longint x);
`ifdef INTEGRAL_CLAMP_EN
    if (x > INT_MAX)  return INT_MAX;
    if (x < -INT_MAX) return -INT_MAX;
`endif
    return x;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_adc_arm"},  o_adc_arm, 0);
    check({tag, "_dac_arm"},  o_dac_arm, 0);
    check({tag, "_done"},     o_loop_done, 0);
    check({tag, "_actual"},   o_actual, 0);
    check({tag, "_setpoint"}, o_setpoint, 0);
    check({tag, "_kp"},       o_kp, 0);
    check({tag, "_ki"},       o_ki, 0);
    check({tag, "_integral"}, o_integral, 0);
    check({tag, "_dac_data"}, o_dac_data, 0);
  endtask

  task automatic wait_adc_arm(input string tag);
    int n = 0;
    while (o_adc_arm !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_adc_arm_seen"}, o_adc_arm, 1);
  endtask

  // One full loop iteration, from a pending ADC request to the post-done cycle.
  task automatic run_iter(input int adc, input int sp, input int kp, input int ki,
                          input int adc_dly, input int dac_dly, input bit dac_early,
                          input bit hold_adc, input bit drop_en);
    longint err, new_int, pd, exp_int, exp_dac;
    wait_adc_arm("iter");
    i_setpoint = IW'(sp);
    i_kp       = IW'(kp);
    i_ki       = IW'(ki);
    repeat (adc_dly) @(negedge clk);
    i_adc_data     = IW'(adc);
    i_adc_finished = 1'b1;
    @(negedge clk);
    check("adc_arm_cleared", o_adc_arm, 0);
    check("actual",   $signed(o_actual), adc);
    check("setpoint", $signed(o_setpoint), sp);
    check("kp",       $signed(o_kp), kp);
    check("ki",       $signed(o_ki), ki);
    if (!hold_adc) i_adc_finished = 1'b0;
    i_setpoint = IW'($urandom);
    i_kp       = IW'($urandom);
    i_ki       = IW'($urandom);
    i_adc_data = IW'($urandom);

    err     = longint'(adc) - longint'(sp);
    new_int = model_int + longint'(ki) * err;
    pd      = longint'(kp) * err + new_int;
    exp_int = clamp_ref(new_int);
    exp_dac = sat_ref(pd);

    for (int k = 1; k <= PL; k++) begin
      @(negedge clk);
      if (drop_en && k == 2) i_enable = 1'b0;
      if (dac_early && k == 2) i_dac_finished = 1'b1;
      check("dac_arm_too_early", o_dac_arm, 0);
      check("shadow_stable", $signed(o_setpoint), sp);
    end
    @(negedge clk);
    check("dac_arm_at_latency", o_dac_arm, 1);
    check("dac_data", $signed(o_dac_data), exp_dac);
    check("integral", $signed(o_integral), exp_int);
    model_int = exp_int;

    if (!dac_early) begin
      repeat (dac_dly) begin
        @(negedge clk);
        check("dac_arm_held", o_dac_arm, 1);
      end
      i_dac_finished = 1'b1;
    end
    @(negedge clk);
    check("loop_done_pulse", o_loop_done, 1);
    check("dac_arm_cleared", o_dac_arm, 0);
    i_dac_finished = 1'b0;
    @(negedge clk);
    check("loop_done_single", o_loop_done, 0);
  endtask

  initial begin
    rst = 1'b1;
    i_enable = 1'b0;
    i_setpoint = '0; i_kp = '0; i_ki = '0; i_adc_data = '0;
    i_adc_finished = 1'b0;
    i_dac_finished = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_no_arm", o_adc_arm, 0);
    end

    // Single iteration and integral accumulation (clamped when the macro is set).
    i_enable = 1'b1;
    @(negedge clk);
    check("arm_one_cycle", o_adc_arm, 1);
    run_iter(100, 0, 2, 1, 0, 0, 1'b0, 1'b0, 1'b0);
    check("t2_integral", $signed(o_integral), 100);
    check("t2_dac", $signed(o_dac_data), 300);
    run_iter(100, 0, 2, 1, 1, 1, 1'b0, 1'b0, 1'b0);
`ifdef INTEGRAL_CLAMP_EN
    check("t6_integral", $signed(o_integral), 150);
`else
    check("t6_integral", $signed(o_integral), 200);
`endif

    // Reset in the middle of PIPE_WAIT.
    wait_adc_arm("rst_mid");
    i_setpoint = IW'(5); i_kp = IW'(3); i_ki = IW'(2);
    i_adc_data = IW'(77);
    i_adc_finished = 1'b1;
    @(negedge clk);
    i_adc_finished = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    i_enable = 1'b0;
    @(negedge clk);
    check_all_zero("rst_mid1");
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("rst_mid2");
    model_int = 0;
    repeat (4) begin
      @(negedge clk);
      check("rst_no_arm", o_adc_arm, 0);
      check("rst_no_dac_arm", o_dac_arm, 0);
    end

    // Saturation at both rails.
    i_enable = 1'b1;
    run_iter(10000, 0, 131071, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    check("sat_hi", $signed(o_dac_data), 524287);
    run_iter(-10000, 0, 131071, 0, 2, 0, 1'b0, 1'b0, 1'b0);
    check("sat_lo", $signed(o_dac_data), -524288);

    // Stale ADC finished held through the iteration blocks re-arming.
    run_iter(40, 10, 3, 1, 0, 0, 1'b1, 1'b1, 1'b0);
    check("stale_no_arm0", o_adc_arm, 0);
    repeat (3) begin
      @(negedge clk);
      check("stale_no_arm", o_adc_arm, 0);
    end
    i_adc_finished = 1'b0;
    @(negedge clk);
    check("stale_rearm", o_adc_arm, 1);

    // Enable dropped mid-iteration: the DAC write still completes, then IDLE.
    run_iter(-300, 50, 4, 1, 1, 2, 1'b0, 1'b0, 1'b1);
    repeat (5) begin
      @(negedge clk);
      check("disabled_no_arm", o_adc_arm, 0);
    end
    i_enable = 1'b1;
    @(negedge clk);
    check("reenable_arm", o_adc_arm, 1);

    // Randomized iterations against the loop model.
    for (int it = 0; it < 30; it++) begin
      int adc, sp, kp, ki;
      adc = int'($urandom_range(4000)) - 2000;
      sp  = int'($urandom_range(2000)) - 1000;
      kp  = (it % 7 == 3) ? 131071 - int'($urandom_range(100)) : int'($urandom_range(127)) - 64;
      ki  = int'($urandom_range(15)) - 8;
      run_iter(adc, sp, kp, ki, int'($urandom_range(3)), int'($urandom_range(3)),
               1'($urandom_range(1)), 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pi_loop_sequencer.md
# pi_loop_sequencer

Control-loop sequencer on the far side of the PI pipeline: it requests ADC conversions, presents the sampled value, setpoint, gains and stored integral to the pipeline, waits for the result, and writes the saturated output to the DAC. It owns the loop's integral state and pipeline-latency bookkeeping. It sits between the ADC/DAC peripheral masters and the PI arithmetic pipeline.

## Interface

Parameters:
- INPUT_WIDTH, 18: width of ADC sample, setpoint and gains.
- OUTPUT_WIDTH, 32: width of the integral and the pipeline result.
- DAC_WIDTH, 20: width of the DAC word (two's complement).
- PIPE_LATENCY, 4: clock edges from a change in the pipeline inputs to a valid pipeline result.
- INTEGRAL_MAX, 1<<30: symmetric integral limit; used only with the configuration macro.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- i_enable  in  1  run loop iterations while high.
- i_setpoint, i_kp, i_ki  in  INPUT_WIDTH each  live setpoint and gains (signed).
- o_adc_arm  out  1  ADC conversion request.
- i_adc_finished  in  1  ADC conversion done (level).
- i_adc_data  in  INPUT_WIDTH  signed ADC sample.
- o_actual, o_setpoint, o_kp, o_ki  out  INPUT_WIDTH each  shadowed values to the pipeline.
- o_integral  out  OUTPUT_WIDTH  stored integral, to pipeline integral input.
- i_integral  in  OUTPUT_WIDTH  updated integral from the pipeline.
- i_pd_out  in  OUTPUT_WIDTH  pipeline result (signed).
- o_dac_arm  out  1  DAC write request.
- i_dac_finished  in  1  DAC write done (level).
- o_dac_data  out  DAC_WIDTH  saturated DAC word.
- o_loop_done  out  1  one-cycle pulse per completed iteration.

## Operation

- All outputs are registered. Reset value of every output is 0; state is IDLE and the wait counter is 0.
- The states are IDLE, ADC_WAIT, PIPE_WAIT, DAC_WAIT and REARM.
- **IDLE:** if i_enable is high and i_adc_finished is low, set o_adc_arm high and go to ADC_WAIT.
- **ADC_WAIT:** o_adc_arm is held high. On the first edge with i_adc_finished high:
  - latch o_actual ← i_adc_data;
  - latch o_setpoint ← i_setpoint, o_kp ← i_kp, o_ki ← i_ki;
  - clear o_adc_arm, clear the counter and go to PIPE_WAIT.
- **Shadowing:** the setpoint and gain shadows change only on this edge, so the pipeline inputs stay constant for the whole iteration.
- **PIPE_WAIT:** the counter increments each edge while it is below PIPE_LATENCY. On the edge where the counter equals PIPE_LATENCY:
  - latch o_integral ← i_integral, clamped when the configuration macro is defined;
  - latch o_dac_data ← sat(i_pd_out);
  - set o_dac_arm and go to DAC_WAIT.
- **DAC_WAIT:** o_dac_arm is held high. On the edge with i_dac_finished high, clear o_dac_arm, pulse o_loop_done and go to REARM.
- **REARM:** wait until i_adc_finished and i_dac_finished are both low.
  - Then, if i_enable is high, set o_adc_arm and go to ADC_WAIT.
  - Otherwise go to IDLE.
- **Saturation rule for sat(x):**
  - x > 2^(DAC_WIDTH-1)−1 gives 2^(DAC_WIDTH-1)−1.
  - x < −2^(DAC_WIDTH-1) gives −2^(DAC_WIDTH-1).
  - Otherwise the result is the low DAC_WIDTH bits of x.
  - Comparison is signed at OUTPUT_WIDTH.
- **Deasserting i_enable** has no effect until REARM. An iteration in progress always completes, including its DAC write.
- **Held integral:** o_integral is held between iterations and while in IDLE. Only rst clears it.
- **Reset mid-operation:** rst in any state returns the block to IDLE with all outputs 0 on the same edge. This drops o_adc_arm and o_dac_arm even if a peripheral transaction is in progress.
- **Finished signals:** a finished signal that is already high on entry to a WAIT state is accepted on the first edge. REARM prevents stale finished levels from re-triggering.

## Timing

- o_adc_arm rises 1 cycle after the edge that samples i_enable high in IDLE or REARM.
- Let E0 be the ADC latch edge. o_integral, o_dac_data and o_dac_arm update at edge E0+PIPE_LATENCY+1, which is E0+5 by default.
- o_loop_done is high for exactly the one cycle after the edge that sees i_dac_finished.
- With zero-latency peripherals, the minimum iteration is:
  - 1 cycle of ADC handshake;
  - PIPE_LATENCY+1 cycles of pipeline wait;
  - 1 cycle of DAC handshake;
  - at least 1 cycle of REARM.

## Configuration

- Macro: INTEGRAL_CLAMP_EN.
- **Defined:** on the PIPE_WAIT latch edge, i_integral is clamped to [−INTEGRAL_MAX, INTEGRAL_MAX] before it is stored in o_integral.
- **Undefined:** i_integral is stored unmodified and INTEGRAL_MAX is unused.

## Test plan

All scenarios use the real pipeline in the bench, where error = actual − setpoint.

1. **Reset.** Assert rst for 2 cycles mid-PIPE_WAIT -> all outputs read 0, state is IDLE, and no arm rises while i_enable is low.
2. **Single iteration.** setpoint=0, kp=2, ki=1, ADC returns 100 -> o_integral=100, o_dac_data=300 at E0+5, one o_loop_done pulse.
3. **Saturation.** kp=131071, ki=0, ADC returns 10000 -> o_dac_data=524287. ADC returns −10000 -> o_dac_data=−524288.
4. **Enable dropped.** Drop i_enable during PIPE_WAIT -> DAC write still completes with the correct value, then IDLE, and o_adc_arm stays 0.
5. **Stale finished.** Hold i_adc_finished high after a conversion -> REARM does not re-arm until it falls. After it falls, o_adc_arm rises 1 cycle later.
6. **Integral clamp.** With INTEGRAL_CLAMP_EN defined, INTEGRAL_MAX=150, two iterations of ADC 100 with setpoint 0 -> o_integral=100, then 150. Without the macro -> 100, then 200.
